// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types and helpers for the debug-FIFO write arbiter
// and any sibling scheduler that reuses rr_pick.
//   arb_state_e  - arbiter FSM states
//   DEF_*        - default FIFO geometry
//   onehot()     - index to one-hot, sized for the largest supported requester count
package fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_DEPTH      = 16;

  // Upper bound on requesters; callers truncate the result to their own width.
  localparam int ARB_MAX_REQ = 8;
  localparam int ARB_IW      = 3;

  function automatic logic [ARB_MAX_REQ-1:0] onehot(input logic [ARB_IW-1:0] idx);
    return ARB_MAX_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
//   req_i   - request vector
//   ptr_i   - highest-priority index this cycle
//   idx_o   - first requesting index at or above ptr_i, wrapping N-1 -> 0
//   found_o - at least one request present
module rr_pick #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] idx_o,
  output logic          found_o
);

  // Walk from the farthest candidate back to ptr_i so the nearest one wins.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      int c;
      c = int'(ptr_i) + i;
      if (c >= N) c = c - N;
      if (req_i[c]) begin
        idx_o   = IW'(c);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: shares the debug FIFO write port between NUM_REQ requesters.
// Round-robin with packet locking, credit-based flow control.
//   clk_i, rst_i      - write-domain clock, sync active-high reset
//   req_valid_i/last  - per-requester beat valid / final beat of packet
//   req_data_i        - packed data, requester k at [k*DATA_WIDTH +: DATA_WIDTH]
//   req_ready_o       - per-requester accept (beat moves on valid&ready)
//   credit_ret_i      - one pulse per word drained on the read side
//   fifo_wen_o/wdata  - registered FIFO write strobe and data
//   grant_o           - one-hot current owner, 0 when none
//   credits_o         - free FIFO slots as seen by the writer
//   err_o             - sticky: credit returned while already full
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int DEPTH      = DEF_DEPTH,
  localparam int CNT_W      = $clog2(DEPTH) + 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]            req_last_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic                          credit_ret_i,
  output logic                          fifo_wen_o,
  output logic [DATA_WIDTH-1:0]         fifo_wdata_o,
  output logic [NUM_REQ-1:0]            grant_o,
  output logic [CNT_W-1:0]              credits_o,
  output logic                          err_o
);

  localparam int IW = $clog2(NUM_REQ);

  arb_state_e              state_q, state_d;
  logic [IW-1:0]           ptr_q, ptr_d;
  logic [IW-1:0]           owner_q, owner_d;
  logic [CNT_W-1:0]        credits_q, credits_d;
  logic                    err_q, err_d;
  logic                    wen_q;
  logic [DATA_WIDTH-1:0]   wdata_q;

  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_data;
  logic [IW-1:0]           pick_idx, sel_idx, sel_nxt;
  logic                    pick_found, sel_ok, has_credit, xfer;

  assign req_data = req_data_i;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req_i   (req_valid_i),
    .ptr_i   (ptr_q),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    credits_d   = credits_q;
    err_d       = err_q;
    grant_o     = '0;
    req_ready_o = '0;

    has_credit = (credits_q != '0);
    sel_idx    = pick_idx;
    sel_ok     = pick_found;
    if (state_q == ARB_LOCKED) begin
      sel_idx = owner_q;
      sel_ok  = 1'b1;
    end
    sel_nxt = (sel_idx == IW'(NUM_REQ - 1)) ? '0 : sel_idx + 1'b1;

    // A locked owner keeps its grant through credit starvation; an idle
    // pick is only advertised when it could actually move a beat. Ready
    // sees registered credits only, never credit_ret_i.
    if (!rst_i && sel_ok && (state_q == ARB_LOCKED || has_credit))
      grant_o = NUM_REQ'(onehot(ARB_IW'(sel_idx)));
    if (has_credit)
      req_ready_o = grant_o;

    xfer = |(req_valid_i & req_ready_o);

    if (xfer) begin
      if (req_last_i[sel_idx]) begin
        state_d = ARB_IDLE;
        ptr_d   = sel_nxt;
      end else begin
        state_d = ARB_LOCKED;
        owner_d = sel_idx;
      end
    end

    unique case ({xfer, credit_ret_i})
      2'b10:   credits_d = credits_q - 1'b1;
      2'b01: begin
        if (credits_q == CNT_W'(DEPTH)) err_d = 1'b1;
        else                            credits_d = credits_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ARB_IDLE;
      ptr_q     <= '0;
      owner_q   <= '0;
      credits_q <= CNT_W'(DEPTH);
      err_q     <= 1'b0;
      wen_q     <= 1'b0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      credits_q <= credits_d;
      err_q     <= err_d;
      wen_q     <= xfer;
      if (xfer) wdata_q <= req_data[sel_idx];
    end
  end

  assign fifo_wen_o   = wen_q;
  assign fifo_wdata_o = wdata_q;
  assign credits_o    = credits_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int D  = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_last, req_ready, grant;
  logic [N*DW-1:0] req_data;
  logic            credit_ret, fifo_wen, err;
  logic [DW-1:0]   fifo_wdata;
  logic [4:0]      credits;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: owner (-1 = none), rr pointer, credit count, write regs.
  int          m_owner, m_ptr, m_cred;
  bit          m_err, m_wen;
  logic [31:0] m_wdata;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .DEPTH(D)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_data_i   (req_data),
    .req_last_i   (req_last),
    .req_ready_o  (req_ready),
    .credit_ret_i (credit_ret),
    .fifo_wen_o   (fifo_wen),
    .fifo_wdata_o (fifo_wdata),
    .grant_o      (grant),
    .credits_o    (credits),
    .err_o        (err)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic m_reset();
    m_owner = -1; m_ptr = 0; m_cred = D; m_err = 0; m_wen = 0; m_wdata = '0;
  endtask

  function automatic logic [N*DW-1:0] rnd_data();
    logic [N*DW-1:0] d;
    for (int k = 0; k < N; k++) d[k*DW +: DW] = $urandom;
    return d;
  endfunction

  // Drive one cycle of inputs, check outputs mid-cycle, then advance model.
  task automatic step(input logic [N-1:0] v, input logic [N-1:0] l,
                      input logic [N*DW-1:0] d, input logic ret, input logic r);
    logic [N-1:0] eg, er;
    int win;
    bit xf;
    req_valid = v; req_last = l; req_data = d; credit_ret = ret; rst = r;
    @(negedge clk);
    eg = '0; er = '0; win = -1;
    if (!r) begin
      if (m_owner >= 0) begin
        win = m_owner;
        eg[win] = 1'b1;
      end else begin
        for (int j = 0; j < N; j++) begin
          int k;
          k = (m_ptr + j) % N;
          if (win < 0 && v[k]) win = k;
        end
        if (win >= 0 && m_cred > 0) eg[win] = 1'b1;
      end
      if (m_cred > 0) er = eg;
    end
    chk("grant",   64'(grant),      64'(eg));
    chk("ready",   64'(req_ready),  64'(er));
    chk("credits", 64'(credits),    64'(m_cred));
    chk("wen",     64'(fifo_wen),   64'(m_wen));
    chk("wdata",   64'(fifo_wdata), 64'(m_wdata));
    chk("err",     64'(err),        64'(m_err));
    xf = (win >= 0) && er[win] && v[win];
    @(posedge clk);
    #1;
    if (r) m_reset();
    else begin
      m_wen = xf;
      if (xf) m_wdata = d[win*DW +: DW];
      if (xf && !ret) m_cred--;
      else if (ret && !xf) begin
        if (m_cred == D) m_err = 1;
        else m_cred++;
      end
      if (xf) begin
        if (l[win]) begin m_owner = -1; m_ptr = (win + 1) % N; end
        else m_owner = win;
      end
    end
  endtask

  initial begin
    logic [N*DW-1:0] dat;
    rst = 1'b1; req_valid = '0; req_last = '0; req_data = '0; credit_ret = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m_reset();

    // Reset state, no requests.
    step('0, '0, '0, 1'b0, 1'b0);

    // Locked 3-beat packet from req1 while req2 waits.
    dat = '0; dat[1*DW +: DW] = 32'hA0; dat[2*DW +: DW] = 32'hB0;
    step(4'b0110, 4'b0000, dat, 1'b0, 1'b0);
    chk("s2_a0", 64'(fifo_wdata), 64'h00A0);
    dat[1*DW +: DW] = 32'hA1;
    step(4'b0110, 4'b0000, dat, 1'b0, 1'b0);
    chk("s2_a1", 64'(fifo_wdata), 64'h00A1);
    dat[1*DW +: DW] = 32'hA2;
    step(4'b0110, 4'b0010, dat, 1'b0, 1'b0);
    chk("s2_a2", 64'(fifo_wdata), 64'h00A2);
    step(4'b0100, 4'b0100, dat, 1'b0, 1'b0);
    chk("s2_b0", 64'(fifo_wdata), 64'h00B0);

    // Reset in the middle of a 4-beat req3 packet.
    step(4'b1000, 4'b0000, rnd_data(), 1'b0, 1'b0);
    step(4'b1000, 4'b0000, rnd_data(), 1'b0, 1'b0);
    step(4'b1000, 4'b0000, rnd_data(), 1'b0, 1'b1);
    chk("s6_cred", 64'(credits),  64'd16);
    chk("s6_wen",  64'(fifo_wen), 64'd0);
    dat = rnd_data();
    step(4'b1111, 4'b1111, dat, 1'b0, 1'b0);
    chk("s6_req0", 64'(fifo_wdata), 64'(dat[0 +: DW]));

    // Back-to-back single-beat packets drain all credits.
    step('0, '0, '0, 1'b0, 1'b1);
    repeat (20) step(4'b1111, 4'b1111, rnd_data(), 1'b0, 1'b0);
    chk("s1_cred0", 64'(credits),   64'd0);
    chk("s1_rdy0",  64'(req_ready), 64'd0);

    // One returned credit lets exactly one beat through.
    step(4'b0001, 4'b0001, rnd_data(), 1'b1, 1'b0);
    chk("s3_cred1", 64'(credits), 64'd1);
    step(4'b0001, 4'b0001, rnd_data(), 1'b0, 1'b0);
    chk("s3_cred0", 64'(credits),  64'd0);
    chk("s3_wen1",  64'(fifo_wen), 64'd1);
    step(4'b0001, 4'b0001, rnd_data(), 1'b0, 1'b0);
    chk("s3_wen0",  64'(fifo_wen), 64'd0);

    // Refill, then simultaneous transfer + return at credits=5.
    repeat (16) step('0, '0, '0, 1'b1, 1'b0);
    chk("refill", 64'(credits), 64'd16);
    repeat (11) step(4'b0001, 4'b0001, rnd_data(), 1'b0, 1'b0);
    step(4'b0001, 4'b0001, rnd_data(), 1'b1, 1'b0);
    chk("s4_cred5", 64'(credits), 64'd5);

    // Return while full sets the sticky error.
    repeat (11) step('0, '0, '0, 1'b1, 1'b0);
    chk("s5_pre_err", 64'(err), 64'd0);
    step('0, '0, '0, 1'b1, 1'b0);
    chk("s5_cred16", 64'(credits), 64'd16);
    chk("s5_err",    64'(err),     64'd1);
    step('0, '0, '0, 1'b0, 1'b0);
    chk("s5_sticky", 64'(err), 64'd1);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++)
      step(N'($urandom), N'($urandom & $urandom), rnd_data(),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 99) == 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
